fp_add_arbiter: RTL and testbench
=================================

Name: fp_add_arbiter

Overview:
- Shares one pipelined floating-point adder among NUM_REQ requesters.
- Each requester uses a valid/ready handshake; arbitration is round-robin.
- The arbiter registers the winning operand pair onto the adder inputs and tracks each in-flight operation with a tag pipeline matched to the adder latency.
- Each result is returned with the originating requester ID. It sits between the complex-MAC/FFT butterfly issue logic and a single shared adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- I_EXP, 8, exponent width
- I_MNT, 23, mantissa width
- I_DATA, I_EXP+I_MNT+1, operand/result width
- ADD_LAT, 3, cycles from adder input sampled to result valid on the adder output (fixed, no stall)
- ID_W, $clog2(NUM_REQ), requester ID width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- en  in  1  grant enable; 0 blocks new grants, in-flight ops drain
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant (one-hot or zero)
- req_a  in  NUM_REQ*I_DATA  operand A, requester i at [i*I_DATA +: I_DATA]
- req_b  in  NUM_REQ*I_DATA  operand B, same packing
- add_a  out  I_DATA  registered operand A to shared adder
- add_b  out  I_DATA  registered operand B to shared adder
- add_res  in  I_DATA  shared adder result
- rsp_valid  out  1  result valid (no backpressure)
- rsp_id  out  ID_W  requester ID of current result
- rsp_data  out  I_DATA  result data
- inflight  out  $clog2(ADD_LAT+2)  ops issued but not yet returned
- idle  out  1  high when inflight==0 and no grant this cycle

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high. The shared adder must be reset by the same reset.
- Reset values: add_a=0, add_b=0, tag pipeline all invalid, rr pointer=0, rsp_valid=0, rsp_id=0, rsp_data=0, inflight=0, idle=1, req_ready=0 during reset.
- Arbitration (combinational): when en=1 and reset=0, grant the first i with req_valid[i]=1, searching from rr pointer p upward modulo NUM_REQ.
  - req_ready = one-hot of the grant; all-zero if no valid or en=0.
  - At most one grant per cycle.
  - req_ready depends only on req_valid, en and p, never on operand data.
- Handshake: a transfer occurs in cycle t when req_valid[i] & req_ready[i]. Requesters hold valid and operands stable until transfer. Deasserting valid before transfer is allowed (request withdrawn, no side effect).
- Pointer update: on a transfer from i, p <= (i+1) mod NUM_REQ. No transfer leaves p unchanged.
- Issue: on transfer at cycle t, add_a/add_b <= req_a/req_b of requester i; visible cycle t+1. With no transfer, add_a/add_b hold their previous value, and the adder output is ignored via the tag.
- Tag pipeline: ADD_LAT+1 stages of {valid, id}. Stage 0 loads {transfer, i} each cycle; all stages shift every cycle, unconditionally.
- Response: the last stage drives rsp_valid/rsp_id. Result for a transfer in cycle t has rsp_valid=1 in cycle t+1+ADD_LAT (t+4 by default), rsp_data = add_res that cycle. rsp_data = 0 when rsp_valid=0.
- Throughput: one op per cycle sustained; results return in issue order.
- inflight: +1 on transfer, -1 on rsp_valid, net 0 when both occur; maximum ADD_LAT+1.
- en deasserted mid-stream: no new grants; in-flight results still return on schedule; idle rises the cycle after the last rsp_valid.
- Reset mid-operation: all tags invalidate, so no rsp_valid is produced for ops in flight at reset. p returns to 0.
- NUM_REQ not a power of two: p wraps NUM_REQ-1 -> 0. IDs >= NUM_REQ are never produced.

Test Plan:
- Single op: req0 a=0x3F800000 (1.0), b=0x40000000 (2.0), transfer at cycle 5 -> rsp_valid in cycle 9 only, rsp_id=0, rsp_data=0x40400000 (3.0); inflight 1 during cycles 6..9, idle high again from cycle 10.
- Round-robin fairness: all 4 requesters hold valid for 8 cycles from reset (p=0) -> grant order 0,1,2,3,0,1,2,3, one per cycle; rsp_id stream repeats the same order 4 cycles later, back-to-back.
- Priority rotation: only req2 and req3 valid, p=0 -> grants 2,3,2,3; then req1 added after the grant to 3 -> next grant is 1.
- Back-to-back data: req1 issues 0x3FC00000+0x3F000000 (1.5+0.5), then 0x40000000+0xBF000000 (2.0-0.5) in consecutive cycles -> consecutive rsp_valid with rsp_data 0x40000000 (2.0) then 0x3FC00000 (1.5), rsp_id=1 both.
- en gating: en=0 with req0 valid -> req_ready=0 indefinitely; en=1 -> grant next cycle, result 4 cycles after the transfer.
- Reset mid-flight: 3 ops issued, reset asserted one cycle later for 1 cycle -> no rsp_valid ever appears for them, inflight=0, p=0, next grant restarts at requester 0.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter that shares one pipelined floating-point adder among NUM_REQ requesters.
// A tag pipeline matched to the adder latency returns each result with its requester ID.
module fp_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int I_EXP   = 8,
    parameter int I_MNT   = 23,
    parameter int I_DATA  = I_EXP + I_MNT + 1,
    parameter int ADD_LAT = 3,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = $clog2(ADD_LAT + 2)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*I_DATA-1:0] req_a,
    input  logic [NUM_REQ*I_DATA-1:0] req_b,
    output logic [I_DATA-1:0]         add_a,
    output logic [I_DATA-1:0]         add_b,
    input  logic [I_DATA-1:0]         add_res,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [I_DATA-1:0]         rsp_data,
    output logic [CNT_W-1:0]          inflight,
    output logic                      idle
);

    logic [ID_W-1:0]   ptr_r;
    logic [NUM_REQ-1:0] grant_s;
    logic [ID_W-1:0]   grant_id_s;
    logic [ID_W-1:0]   cand_s;
    logic              xfer_s;
    logic              tag_v_r  [0:ADD_LAT];
    logic [ID_W-1:0]   tag_id_r [0:ADD_LAT];

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return ID_W'(s);
    endfunction

    // Round-robin search from the pointer; the grant never looks at operand data.
    always_comb begin
        grant_s    = '0;
        grant_id_s = '0;
        cand_s     = '0;
        xfer_s     = 1'b0;
        if (en && !reset) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand_s = wrap_idx(ptr_r, k);
                if (!xfer_s && req_valid[cand_s]) begin
                    grant_s[cand_s] = 1'b1;
                    grant_id_s      = cand_s;
                    xfer_s          = 1'b1;
                end else begin
                    xfer_s = xfer_s;
                end
            end
        end else begin
            xfer_s = 1'b0;
        end
    end

    assign req_ready = grant_s;

    // Pointer advances past the winner so it has lowest priority next time.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r <= '0;
        end else if (xfer_s) begin
            if (grant_id_s == ID_W'(NUM_REQ - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= grant_id_s + ID_W'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Operand registers feeding the shared adder; hold when nothing is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            add_a <= '0;
            add_b <= '0;
        end else if (xfer_s) begin
            add_a <= req_a[int'(grant_id_s)*I_DATA +: I_DATA];
            add_b <= req_b[int'(grant_id_s)*I_DATA +: I_DATA];
        end else begin
            add_a <= add_a;
            add_b <= add_b;
        end
    end

    // Tag pipeline: one stage for the operand register plus ADD_LAT adder stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k <= ADD_LAT; k++) begin
                tag_v_r[k]  <= 1'b0;
                tag_id_r[k] <= '0;
            end
        end else begin
            tag_v_r[0]  <= xfer_s;
            tag_id_r[0] <= grant_id_s;
            for (int k = 1; k <= ADD_LAT; k++) begin
                tag_v_r[k]  <= tag_v_r[k-1];
                tag_id_r[k] <= tag_id_r[k-1];
            end
        end
    end

    assign rsp_valid = tag_v_r[ADD_LAT];
    assign rsp_id    = tag_id_r[ADD_LAT];

    // Adder output is only meaningful when the matching tag is valid.
    always_comb begin
        rsp_data = '0;
        if (rsp_valid) begin
            rsp_data = add_res;
        end else begin
            rsp_data = '0;
        end
    end

    // Outstanding-operation counter; issue and return in one cycle cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            case ({xfer_s, rsp_valid})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    assign idle = (inflight == CNT_W'(0)) && !xfer_s;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a 3-stage behavioural model of the shared adder.
// Expected values are hand-computed per vector.
module tb_fp_add_arbiter;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;
    localparam int CW  = 3;

    logic             clk;
    logic             reset;
    logic             en;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [W-1:0]     add_a;
    logic [W-1:0]     add_b;
    logic [W-1:0]     add_res;
    logic             rsp_valid;
    logic [IDW-1:0]   rsp_id;
    logic [W-1:0]     rsp_data;
    logic [CW-1:0]    inflight;
    logic             idle;
    logic [W-1:0]     s1, s2, s3;

    int n_vec = 0;
    int n_err = 0;

    fp_add_arbiter dut (
        .clk(clk), .reset(reset), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .add_a(add_a), .add_b(add_b), .add_res(add_res),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .inflight(inflight), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Known sums for the directed vectors; anything else gets an arbitrary value.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: return 32'h40400000;
            64'h3FC00000_3F000000: return 32'h40000000;
            64'h40000000_BF000000: return 32'h3FC00000;
            default:               return a ^ b;
        endcase
    endfunction

    // Shared adder model: sampled at the edge after add_a/add_b appear, result three edges later.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= fadd(add_a, add_b);
            s2 <= s1;
            s3 <= s2;
        end
    end
    assign add_res = s3;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] t3_ready [0:4];
    int         t3_ids   [0:4];

    initial begin
        t3_ready = '{4'b0100, 4'b1000, 4'b0100, 4'b1000, 4'b0010};
        t3_ids   = '{2, 3, 2, 3, 1};

        reset = 1'b1; en = 1'b1; req_valid = '1; req_a = '0; req_b = '0;
        next_cycle();
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_inflight", inflight, 0);
        check("rst_idle", idle, 1);
        next_cycle();
        reset = 1'b0; req_valid = '0;
        next_cycle();

        // Single op from requester 0
        req_valid = 4'b0001;
        req_a[0*W +: W] = 32'h3F800000;
        req_b[0*W +: W] = 32'h40000000;
        @(negedge clk);
        check("t1_ready", req_ready, 4'b0001);
        check("t1_idle_xfer", idle, 0);
        next_cycle();
        req_valid = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) check("t1_add_a", add_a, 32'h3F800000);
            if (k == 1) check("t1_add_b", add_b, 32'h40000000);
            check("t1_rsp_valid", rsp_valid, (k == 4) ? 1 : 0);
            check("t1_rsp_data", rsp_data, (k == 4) ? 32'h40400000 : 32'h0);
            if (k == 4) check("t1_rsp_id", rsp_id, 0);
            check("t1_inflight", inflight, (k <= 4) ? 1 : 0);
            check("t1_idle", idle, (k >= 5) ? 1 : 0);
            next_cycle();
        end

        // Round-robin fairness from p=0
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            req_valid = (k < 8) ? 4'hF : 4'h0;
            @(negedge clk);
            if (k < 8) check("t2_ready", req_ready, 4'b0001 << (k % 4));
            if (k >= 4) check("t2_rsp_valid", rsp_valid, 1);
            if (k >= 4) check("t2_rsp_id", rsp_id, (k - 4) % 4);
            if (k == 4) check("t2_inflight_max", inflight, 4);
            next_cycle();
        end

        // Priority rotation: 2,3,2,3 then 1 joins
        for (int k = 0; k < 9; k++) begin
            req_valid = (k < 4) ? 4'b1100 : ((k == 4) ? 4'b1110 : 4'b0000);
            @(negedge clk);
            if (k < 5) check("t3_ready", req_ready, t3_ready[k]);
            else check("t3_ready_idle", req_ready, 0);
            if (k >= 4) check("t3_rsp_valid", rsp_valid, 1);
            if (k >= 4) check("t3_rsp_id", rsp_id, t3_ids[k-4]);
            next_cycle();
        end
        req_valid = '0;
        next_cycle();

        // Back-to-back data from requester 1
        for (int k = 0; k < 7; k++) begin
            if (k == 0) begin
                req_valid = 4'b0010;
                req_a[1*W +: W] = 32'h3FC00000;
                req_b[1*W +: W] = 32'h3F000000;
            end else if (k == 1) begin
                req_a[1*W +: W] = 32'h40000000;
                req_b[1*W +: W] = 32'hBF000000;
            end else begin
                req_valid = '0;
            end
            @(negedge clk);
            if (k < 2) check("t4_ready", req_ready, 4'b0010);
            check("t4_rsp_valid", rsp_valid, (k == 4 || k == 5) ? 1 : 0);
            if (k == 4) check("t4_data0", rsp_data, 32'h40000000);
            if (k == 5) check("t4_data1", rsp_data, 32'h3FC00000);
            if (k == 4 || k == 5) check("t4_rsp_id", rsp_id, 1);
            next_cycle();
        end

        // en gating, then en dropped while the op drains
        en = 1'b0;
        req_valid = 4'b0001;
        for (int k = 0; k < 11; k++) begin
            en = (k == 5) ? 1'b1 : 1'b0;
            @(negedge clk);
            check("t5_ready", req_ready, (k == 5) ? 4'b0001 : 4'b0000);
            check("t5_rsp_valid", rsp_valid, (k == 9) ? 1 : 0);
            if (k == 9) check("t5_rsp_id", rsp_id, 0);
            if (k == 10) check("t5_idle", idle, 1);
            next_cycle();
        end
        en = 1'b1;
        req_valid = '0;
        next_cycle();

        // Reset mid-flight: three ops issued, then a one-cycle reset
        for (int k = 0; k < 4; k++) begin
            req_valid = 4'hF;
            reset = (k == 3) ? 1'b1 : 1'b0;
            @(negedge clk);
            check("t6_ready", req_ready, (k == 3) ? 4'b0000 : (4'b0010 << k));
            next_cycle();
        end
        reset = 1'b0;
        req_valid = '0;
        for (int k = 4; k < 10; k++) begin
            @(negedge clk);
            check("t6_no_rsp", rsp_valid, 0);
            check("t6_inflight", inflight, 0);
            check("t6_idle", idle, 1);
            next_cycle();
        end
        req_valid = 4'hF;
        @(negedge clk);
        check("t6_restart", req_ready, 4'b0001);
        next_cycle();
        req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
